// File: rtl/vga_pkg.sv
// Shared VGA/text-overlay constants and types.
// CNT_W/RGB_W are the timing-counter and colour widths; the text box is
// TEXT_COLS x TEXT_ROWS glyphs of CHAR_W x CHAR_H pixels.
package vga_pkg;
  localparam int CNT_W     = 11;
  localparam int RGB_W     = 12;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int BOX_W     = CHAR_W * TEXT_COLS;  // 128
  localparam int BOX_H     = CHAR_H * TEXT_ROWS;  // 256
  localparam int PIPE_LAT  = 4;

  // VGA sideband that travels alongside each pixel.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } vga_side_t;
endpackage

// File: rtl/draw_rect_char_if.sv
// VGA pixel bus: counters, sync, blanking and colour for one pixel.
// master drives the bus, slave observes it.
interface draw_rect_char_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic [RGB_W-1:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_char_delay.sv
// Generic fixed-latency shift register used to align sideband data.
// Ports: clk, rst_n (async low, clears to 0), din -> dout after CLK_DEL clocks.
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[CLK_DEL-1];
endmodule

// File: rtl/draw_rect_char.sv
// Overlays a 16x16 character text box (8x16 glyphs) on a VGA pixel stream.
// Ports: clk/rst_n; hcount/vcount/hsync/vsync/hblnk/vblnk/rgb *_in from the
// timing chain and the same set *_out delayed by 4 clocks; char_xy -> text ROM,
// char_code <- text ROM (1 clk); font_addr_code/char_line -> font ROM,
// char_pixels <- font ROM (1 clk, bit 7 = leftmost pixel).
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [10:0] X_POS    = 11'd64,
  parameter logic [10:0] Y_POS    = 11'd64,
  parameter logic [11:0] TEXT_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [3:0]  char_line,
  output logic [6:0]  font_addr_code,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  // Stage 1: position relative to the box. Only the low bits are needed and
  // the low bits of a wrapping subtract equal those of the full subtract.
  logic [6:0] rel_x_d;
  logic [7:0] rel_y_d;
  logic       in_box_d;
  logic [7:0] char_xy_d, char_xy_q;
  logic [3:0] line_s1_d, line_s1_q;
  logic [3:0] char_line_d, char_line_q;

  always_comb begin
    rel_x_d   = hcount_in[6:0] - X_POS[6:0];
    rel_y_d   = vcount_in[7:0] - Y_POS[7:0];
    // 12-bit bounds so a box placed near 2047 clips instead of wrapping.
    in_box_d  = ({1'b0, hcount_in} >= {1'b0, X_POS}) &&
                ({1'b0, hcount_in} <  {1'b0, X_POS} + 12'(BOX_W)) &&
                ({1'b0, vcount_in} >= {1'b0, Y_POS}) &&
                ({1'b0, vcount_in} <  {1'b0, Y_POS} + 12'(BOX_H));
    char_xy_d   = {rel_y_d[7:4], rel_x_d[6:3]};
    line_s1_d   = rel_y_d[3:0];
    char_line_d = line_s1_q;   // stage 2: aligned with char_code
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy_q   <= '0;
      line_s1_q   <= '0;
      char_line_q <= '0;
    end else begin
      char_xy_q   <= char_xy_d;
      line_s1_q   <= line_s1_d;
      char_line_q <= char_line_d;
    end
  end

  assign char_xy        = char_xy_q;
  assign char_line      = char_line_q;
  assign font_addr_code = char_code;

  // in_box and pixel column travel 3 clocks to meet char_pixels.
  logic       in_box_s3;
  logic [2:0] px_s3;
  delay #(.WIDTH(4), .CLK_DEL(3)) u_pix_dly (
    .clk(clk), .rst_n(rst_n),
    .din({in_box_d, rel_x_d[2:0]}), .dout({in_box_s3, px_s3})
  );

  // Background colour and blanking aligned with char_pixels for the mux.
  logic        hblnk_s3, vblnk_s3;
  logic [11:0] rgb_s3;
  delay #(.WIDTH(14), .CLK_DEL(3)) u_bg_dly (
    .clk(clk), .rst_n(rst_n),
    .din({hblnk_in, vblnk_in, rgb_in}), .dout({hblnk_s3, vblnk_s3, rgb_s3})
  );

  // Counters/sync/blank go straight through a 4-deep pipe.
  vga_side_t side_in, side_out;
  assign side_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                     vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
  delay #(.WIDTH($bits(vga_side_t)), .CLK_DEL(PIPE_LAT)) u_side_dly (
    .clk(clk), .rst_n(rst_n), .din(side_in), .dout(side_out)
  );

  // Stage 4: composite; blanking always wins over glyph pixels.
  logic [11:0] rgb_out_d, rgb_out_q;
  always_comb begin
    rgb_out_d = rgb_s3;
    if (in_box_s3 && !hblnk_s3 && !vblnk_s3 && char_pixels[3'd7 - px_s3])
      rgb_out_d = TEXT_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_out_q <= '0;
    else        rgb_out_q <= rgb_out_d;
  end

  assign rgb_out    = rgb_out_q;
  assign hcount_out = side_out.hcount;
  assign vcount_out = side_out.vcount;
  assign hsync_out  = side_out.hsync;
  assign vsync_out  = side_out.vsync;
  assign hblnk_out  = side_out.hblnk;
  assign vblnk_out  = side_out.vblnk;
endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: behavioural text/font ROMs, a pixel-level
// reference computed from box geometry, directed steps plus random pixels
// and SVGA 800x600 (1056x628 total) lines through the box.
module tb_draw_rect_char;
  localparam int          XP  = 64;
  localparam int          YP  = 64;
  localparam logic [11:0] TXT = 12'hFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  draw_rect_char_if vin ();
  draw_rect_char_if vout ();

  logic [7:0] char_xy;
  logic [6:0] char_code = '0;
  logic [3:0] char_line;
  logic [6:0] font_addr_code;
  logic [7:0] char_pixels = '0;

  draw_rect_char #(.X_POS(11'd64), .Y_POS(11'd64), .TEXT_RGB(12'hFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(vin.hcount), .vcount_in(vin.vcount),
    .hsync_in(vin.hsync), .vsync_in(vin.vsync),
    .hblnk_in(vin.hblnk), .vblnk_in(vin.vblnk), .rgb_in(vin.rgb),
    .char_xy(char_xy), .char_code(char_code), .char_line(char_line),
    .font_addr_code(font_addr_code), .char_pixels(char_pixels),
    .hcount_out(vout.hcount), .vcount_out(vout.vcount),
    .hsync_out(vout.hsync), .vsync_out(vout.vsync),
    .hblnk_out(vout.hblnk), .vblnk_out(vout.vblnk), .rgb_out(vout.rgb)
  );

  // Registered ROMs.
  logic [6:0] text_mem [256];
  logic [7:0] font_mem [2048];
  always @(posedge clk) begin
    char_code   <= text_mem[char_xy];
    char_pixels <= font_mem[{font_addr_code, char_line}];
  end

  typedef struct {
    int          h, v;
    bit          hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [12:0] want;   // bit 12 set: directed expected colour
  } pix_t;

  pix_t q[$];            // last 4 pixels driven, oldest first
  int tests = 0;
  int fails = 0;

  function automatic logic [11:0] ref_rgb(pix_t p);
    int rx, ry, code;
    logic [7:0] row;
    rx = p.h - XP;
    ry = p.v - YP;
    if (rx >= 0 && rx < 128 && ry >= 0 && ry < 256 && !p.hb && !p.vb) begin
      code = int'(text_mem[(ry / 16) * 16 + rx / 8]);
      row  = font_mem[code * 16 + ry % 16];
      if (row[7 - rx % 8]) return TXT;
    end
    return p.rgb;
  endfunction

  function automatic logic [7:0] ref_xy(pix_t p);
    int rx, ry;
    rx = (p.h - XP) & 2047;
    ry = (p.v - YP) & 2047;
    return 8'(((ry / 16) % 16) * 16 + (rx / 8) % 16);
  endfunction

  function automatic logic [3:0] ref_line(pix_t p);
    return 4'(((p.v - YP) & 2047) % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_outs();
    int n;
    logic [25:0] side_exp;
    n = q.size();
    side_exp = '0;
    if (n == 4)
      side_exp = {11'(q[0].h), 11'(q[0].v), q[0].hs, q[0].vs, q[0].hb, q[0].vb};
    chk("rgb_out", 32'(vout.rgb), n == 4 ? 32'(ref_rgb(q[0])) : 32'd0);
    if (n == 4 && q[0].want[12]) chk("directed_rgb", 32'(vout.rgb), 32'(q[0].want[11:0]));
    chk("sideband", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                        vout.hblnk, vout.vblnk}), 32'(side_exp));
    chk("char_xy", 32'(char_xy), n >= 1 ? 32'(ref_xy(q[n-1])) : 32'd0);
    chk("char_line", 32'(char_line), n >= 2 ? 32'(ref_line(q[n-2])) : 32'd0);
    if (n >= 2) chk("font_addr_code", 32'(font_addr_code), 32'(text_mem[ref_xy(q[n-2])]));
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs,
                       input bit hb, input bit vb, input logic [11:0] rgb,
                       input logic [12:0] want);
    pix_t p;
    p.h = h; p.v = v; p.hs = hs; p.vs = vs; p.hb = hb; p.vb = vb;
    p.rgb = rgb; p.want = want;
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb;
    vin.rgb = rgb;
    if (q.size() == 4) void'(q.pop_front());
    q.push_back(p);
  endtask

  task automatic tick(input int h, input int v, input bit hb, input bit vb,
                      input logic [11:0] rgb, input logic [12:0] want);
    @(negedge clk);
    check_outs();
    drive(h, v, 1'b0, 1'b0, hb, vb, rgb, want);
  endtask

  // One SVGA line segment with real sync/blank timing.
  task automatic frame_px(input int h, input int v);
    @(negedge clk);
    check_outs();
    drive(h, v, (h >= 840 && h < 968), (v >= 601 && v < 605),
          (h >= 800), (v >= 600), 12'($urandom), 13'h0);
  endtask

  int vlist [14] = '{0, 63, 64, 65, 100, 200, 319, 320, 321, 599, 600, 601, 604, 627};

  initial begin
    for (int i = 0; i < 256; i++)  text_mem[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    text_mem[8'h00] = 7'h05;
    text_mem[8'h0F] = 7'h06;
    font_mem[5 * 16] = 8'h80;     // leftmost pixel only
    font_mem[6 * 16] = 8'h01;     // rightmost pixel only
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
    vin.hblnk = 0; vin.vblnk = 0; vin.rgb = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    check_outs();
    drive(64, 64, 0, 0, 0, 0, 12'h123, {1'b1, 12'hFFF});

    // Directed steps.
    tick(65, 64, 0, 0, 12'h456, {1'b1, 12'h456});
    tick(75, 100, 0, 0, 12'h010, 13'h0);
    tick(191, 64, 0, 0, 12'h0A0, {1'b1, 12'hFFF});
    tick(192, 64, 0, 0, 12'h0A0, {1'b1, 12'h0A0});
    tick(64, 64, 1, 0, 12'h321, {1'b1, 12'h321});
    tick(64, 64, 0, 1, 12'h654, {1'b1, 12'h654});
    tick(63, 64, 0, 0, 12'h777, {1'b1, 12'h777});
    tick(64, 63, 0, 0, 12'h888, {1'b1, 12'h888});
    tick(64, 320, 0, 0, 12'h999, {1'b1, 12'h999});
    tick(64, 319, 0, 0, 12'hABC, 13'h0);
    tick(2047, 2047, 0, 0, 12'hDEF, {1'b1, 12'hDEF});

    // Random pixels around the box with occasional blanking.
    for (int i = 0; i < 800; i++)
      tick(int'($urandom_range(40, 220)), int'($urandom_range(40, 340)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           12'($urandom), 13'h0);

    // SVGA lines crossing the box edges and the vertical blank/sync.
    foreach (vlist[k])
      for (int h = 0; h < 1056; h++) frame_px(h, vlist[k]);

    // Asynchronous reset mid-line, then recovery.
    for (int h = 0; h < 150; h++) frame_px(h, 130);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 q.delete();
    check_outs();
    repeat (3) begin @(negedge clk); check_outs(); end
    @(negedge clk);
    rst_n = 1'b1;
    check_outs();
    drive(150, 130, 0, 0, 0, 0, 12'($urandom), 13'h0);
    for (int h = 151; h < 1056; h++) frame_px(h, 130);
    repeat (5) begin @(negedge clk); check_outs(); drive(0, 131, 0, 0, 0, 0, 12'h000, 13'h0); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/draw_rect_char.md
DRAW_RECT_CHAR -- requirements
Module: draw_rect_char

Interface
REQ-001 Parameter X_POS, default 11'd64, horizontal pixel position of the text box's top-left corner.
REQ-002 Parameter Y_POS, default 11'd64, vertical pixel position of the text box's top-left corner.
REQ-003 Parameter TEXT_RGB, default 12'hFFF, colour of foreground (glyph) pixels.
REQ-004 Ports SHALL be as follows, one per line (name, direction, width, meaning), clock and reset first:
- clk, in, 1, pixel clock, the single clock.
- rst_n, in, 1, reset, asynchronous and active-low.
- hcount_in / vcount_in, in, 11 each, VGA pixel counters.
- hsync_in / vsync_in / hblnk_in / vblnk_in, in, 1 each, VGA timing.
- rgb_in, in, 12, background pixel.
- char_xy, out, 8, text-ROM address: [7:4] = row, [3:0] = column.
- char_code, in, 7, text-ROM data; registered, valid 1 clk after char_xy.
- char_line, out, 4, glyph row index to the font ROM.
- font_addr_code, out, 7, char_code forwarded to the font ROM.
- char_pixels, in, 8, font-ROM row; registered, valid 1 clk after font_addr_code/char_line; bit 7 is the leftmost pixel.
- hcount_out / vcount_out, out, 11 each, delayed counters.
- hsync_out / vsync_out / hblnk_out / vblnk_out, out, 1 each, delayed timing.
- rgb_out, out, 12, composited pixel.

Function
REQ-005 Text box SHALL be 16 columns x 16 rows of 8x16-pixel glyphs, i.e. 128 x 256 pixels.
REQ-006 Stage 1 (T+1): rel_x = hcount_in - X_POS and rel_y = vcount_in - Y_POS, 11-bit unsigned, wrap on underflow.
- in_box = (hcount_in >= X_POS) && (hcount_in < X_POS+128) && (vcount_in >= Y_POS) && (vcount_in < Y_POS+256).
- char_xy is registered as {rel_y[7:4], rel_x[6:3]}.
REQ-007 Stage 2 (T+2): font_addr_code = char_code (combinational pass-through); char_line = rel_y[3:0] delayed to align with char_code.
REQ-008 Stage 3 (T+3): char_pixels is valid.
REQ-009 Stage 4 (T+4): outputs are registered.
- rgb_out = TEXT_RGB when in_box(delayed) && !hblnk && !vblnk && char_pixels[7 - rel_x[2:0](delayed)].
- Otherwise rgb_out = rgb_in delayed by 4.
REQ-010 Total latency SHALL be exactly 4 clocks for every output.
- hcount, vcount, sync, blank and rgb_in are each delayed by 4 stages, so outputs stay mutually aligned.
REQ-011 Out-of-box pixels SHALL pass rgb_in through unchanged (delayed); char_xy is don't-care but must stay deterministic.
REQ-012 Box edges: hcount = X_POS+127 is inside; hcount = X_POS+128 is outside; the same rule applies vertically at Y_POS+255 / Y_POS+256.
REQ-013 X_POS/Y_POS near 2047 SHALL use 12-bit comparison for the upper bound, so the box is clipped with no wrap-around.
REQ-014 Blanking SHALL override text: when delayed hblnk or vblnk = 1, rgb_out = delayed rgb_in.
REQ-015 The block has no handshake; it processes one pixel per clock continuously, with no stalls.

Reset
REQ-016 While rst_n = 0, all registers SHALL clear asynchronously.
- Outputs read 0: rgb_out = 12'h000, counts = 0, sync/blank = 0, char_xy = 0, char_line = 0.
REQ-017 After rst_n deasserts mid-frame, outputs SHALL show reset values for exactly 4 clocks, then track inputs with latency 4 and no extra glitch.

Structure
REQ-018 The following constants SHALL live in vga_pkg:
- CHAR_W = 8, CHAR_H = 16.
- TEXT_COLS = 16, TEXT_ROWS = 16.
- Timing widths.
REQ-019 A generic sub-module delay (parameters WIDTH, CLK_DEL; async active-low reset to 0) SHALL implement the sideband alignment pipelines.

Verification
REQ-020 Bench scenarios:
- X_POS = Y_POS = 64, hcount_in = 64, vcount_in = 64 -> char_xy = 8'h00 at T+1; char_line = 0 at T+2.
- hcount_in = 75, vcount_in = 100 -> char_xy = 8'h21 at T+1; char_line = 4'h4 at T+2.
- Model char_pixels = 8'h80 with rel_x[2:0] = 0 -> rgb_out = 12'hFFF at T+4; with rel_x[2:0] = 1 -> rgb_out = rgb_in.
- hcount_in = 192 (edge, X_POS+128), rgb_in = 12'h0A0 -> rgb_out = 12'h0A0 regardless of char_pixels; hcount_in = 191 with a glyph bit set -> 12'hFFF.
- Full 800x600 frame -> hsync_out / vsync_out equal the inputs shifted by exactly 4 clocks; hblnk = 1 with a glyph bit set -> rgb_out = rgb_in.
- Assert rst_n = 0 mid-line -> all outputs 0 immediately (asynchronous); release -> first valid output 4 clocks later.
